rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Parametrised successor to the combinational priority encoder: arbitrates 2**N request lines and produces a registered grant (binary index plus one-hot) with a valid/ready handshake to the consumer.
- Two modes: fixed priority, where the highest index wins, and round-robin, which uses a rotating pointer.
- Sits in front of shared resources (cache refill port, memory bus) that several requesters contend for.
- Sustains one grant per cycle under back-to-back load.

Parameters:
- N, 2, log2 of requester count (2**N requesters, N-bit index); N >= 1.
- MODE, ARB_RR, arb_mode_e: ARB_FIXED or ARB_RR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2**N  request vector; bit i = requester i.
- gnt_ready  in  1  consumer accepts the current grant this cycle.
- gnt_valid  out  1  a grant is presented.
- gnt_idx  out  N  index of the granted requester.
- gnt_onehot  out  2**N  one-hot of gnt_idx; all zero when gnt_valid=0.
- busy  out  1  high when state = GRANT (equals gnt_valid).

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0, ptr=0.
- All outputs come from registers; no combinational path from req or gnt_ready to any output.
- Picker, fixed mode: winner = highest set bit of the candidate vector.
- Picker, round-robin mode: winner = first set bit at or above ptr, scanning upward and wrapping modulo 2**N.
- Picker, empty input: candidate vector all zero -> no winner.
- State IDLE:
  - if |req, register winner(req), set gnt_valid=1, go to GRANT.
  - Latency: req asserted at edge k -> gnt_valid=1 after edge k+1.
- State GRANT:
  - gnt_valid=1 and gnt_ready=0: gnt_idx and gnt_onehot hold stable. No retraction, no re-arbitration, even if higher-priority requests arrive or the granted req drops.
  - gnt_valid=1 and gnt_ready=1: handshake.
    - Round-robin mode: ptr <= gnt_idx+1 (wraps 2**N-1 -> 0). Fixed mode: ptr unused, stays 0.
    - Candidates = req & ~gnt_onehot; the just-served requester is masked for this cycle only.
    - Candidates non-zero: load the new winner (evaluated against the updated pointer), stay in GRANT. Throughput is one grant per cycle.
    - Candidates zero: gnt_valid <= 0, gnt_onehot <= 0, gnt_idx holds, go to IDLE.
- Requester rule: hold req high until the handshake on its index, and drop it the cycle after. A requester still high after service competes normally from the next cycle.
- Single requester continuously high in round-robin mode: re-granted every other cycle (the mask causes one idle cycle), never starved.
- Fairness guarantee (round-robin mode): any continuously asserted request is granted within 2**N handshakes.
- Reset mid-grant: outputs clear immediately on rst assertion, the pending grant is discarded and ptr returns to 0.
- Illegal encoding: none. gnt_idx is always in range and gnt_onehot == (1 << gnt_idx) whenever gnt_valid=1.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR};
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e.
- One combinational sub-module, rr_pick:
  - parameters N and MODE;
  - inputs cand[2**N] and ptr[N];
  - outputs idx[N] and found.
- Implement rr_pick with a double-width unrolled vector, or by masking >= ptr with a fallback to an unmasked search.
- Top level holds the FSM, pointer, and output registers only.

Test Plan:
- Reset and idle: assert rst with req=4'b1111 -> all outputs 0 while rst is high. After release, gnt_valid=1 after one edge, with gnt_idx=0 in round-robin mode or gnt_idx=3 in fixed mode.
- Round-robin rotation (N=2): req=4'b1111 held, gnt_ready=1 -> gnt_idx sequence 0,1,2,3,0,... with gnt_valid continuously 1.
- Backpressure: req=4'b0100, gnt_ready=0 for 5 cycles while req changes to 4'b1100 -> gnt_idx stays 2 and gnt_onehot stays 4'b0100. On gnt_ready=1 the next grant is 3.
- Wrap and mask: ptr=3 after granting 2, req=4'b0101 -> next grant 0. With only req[0] held high, grants occur on alternating cycles.
- Fixed mode starvation check: req=4'b1001 held, gnt_ready=1 -> gnt_idx=3 every grant cycle, alternating with a masked cycle where 0 wins, giving sequence 3,0,3,0.
- Reset mid-operation: assert rst while gnt_valid=1, gnt_idx=2 -> outputs clear asynchronously and the first grant after release restarts from ptr=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the request arbiter: arbitration mode and FSM state.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: highest set bit (fixed) or first set bit at/above ptr with wrap (round-robin).
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter arb_mode_e   MODE = ARB_RR
) (
    input  logic [2**N-1:0] cand,
    input  logic [N-1:0]    ptr,
    output logic [N-1:0]    idx,
    output logic            found
);

    localparam int unsigned W = 2**N;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (MODE == ARB_FIXED) begin
            for (int i = 0; i < int'(W); i++) begin
                if (cand[i]) begin
                    idx   = N'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Lowest set bit overall is the wrap fallback; a set bit at/above ptr overrides it.
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    idx   = N'(i);
                    found = 1'b1;
                end
            end
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (cand[i] && (N'(i) >= ptr)) begin
                    idx = N'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered-grant arbiter over 2**N requesters with valid/ready handshake; fixed or round-robin priority.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter arb_mode_e   MODE = ARB_RR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**N-1:0] req,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [N-1:0]    gnt_idx,
    output logic [2**N-1:0] gnt_onehot,
    output logic            busy
);

    localparam int unsigned W = 2**N;

    arb_state_e     state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [W-1:0]   oh_q, oh_d;

    logic [W-1:0]   pick_cand;
    logic [N-1:0]   pick_ptr;
    logic [N-1:0]   pick_idx;
    logic           pick_found;

    rr_pick #(
        .N    (N),
        .MODE (MODE)
    ) u_pick (
        .cand  (pick_cand),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state: arbitrate from IDLE, or on handshake re-arbitrate with the served requester masked.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        oh_d      = oh_q;
        pick_cand = req;
        pick_ptr  = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    oh_d    = W'(1) << pick_idx;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (gnt_ready) begin
                    if (MODE == ARB_RR) begin
                        ptr_d = idx_q + N'(1);
                    end
                    pick_cand = req & ~oh_q;
                    pick_ptr  = ptr_d;
                    if (pick_found) begin
                        idx_d = pick_idx;
                        oh_d  = W'(1) << pick_idx;
                    end else begin
                        oh_d    = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
        end
    end

    assign gnt_valid  = (state_q == ARB_GRANT);
    assign busy       = (state_q == ARB_GRANT);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = oh_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: round-robin and fixed instances share stimulus, checked against a behavioural model.
module tb_rr_grant_arbiter;
    import arb_pkg::*;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic         gnt_ready;

    logic         rr_valid, rr_busy, fx_valid, fx_busy;
    logic [N-1:0] rr_idx, fx_idx;
    logic [W-1:0] rr_oh, fx_oh;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = round-robin instance, 1 = fixed instance
    bit m_valid [2];
    int m_idx   [2];
    int m_ptr   [2];

    rr_grant_arbiter #(.N(N), .MODE(ARB_RR)) u_rr (
        .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready),
        .gnt_valid(rr_valid), .gnt_idx(rr_idx), .gnt_onehot(rr_oh), .busy(rr_busy)
    );

    rr_grant_arbiter #(.N(N), .MODE(ARB_FIXED)) u_fx (
        .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready),
        .gnt_valid(fx_valid), .gnt_idx(fx_idx), .gnt_onehot(fx_oh), .busy(fx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int win(input logic [W-1:0] c, input int p, input bit rr);
        if (rr) begin
            for (int k = 0; k < int'(W); k++) begin
                if (c[(p + k) % int'(W)]) return (p + k) % int'(W);
            end
        end else begin
            for (int j = int'(W) - 1; j >= 0; j--) begin
                if (c[j]) return j;
            end
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid[i] = 1'b0;
                m_idx[i]   = 0;
                m_ptr[i]   = 0;
            end else if (!m_valid[i]) begin
                if (req != '0) begin
                    m_valid[i] = 1'b1;
                    m_idx[i]   = win(req, m_ptr[i], i == 0);
                end
            end else if (gnt_ready) begin
                logic [W-1:0] c;
                if (i == 0) m_ptr[i] = (m_idx[i] + 1) % int'(W);
                c = req & ~(W'(1) << m_idx[i]);
                if (c != '0) m_idx[i] = win(c, m_ptr[i], i == 0);
                else         m_valid[i] = 1'b0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        logic [W-1:0] e0, e1;
        e0 = m_valid[0] ? W'(1) << m_idx[0] : '0;
        e1 = m_valid[1] ? W'(1) << m_idx[1] : '0;
        chk("rr_valid",  32'(rr_valid), 32'(m_valid[0]));
        chk("rr_busy",   32'(rr_busy),  32'(m_valid[0]));
        chk("rr_idx",    32'(rr_idx),   32'(m_idx[0]));
        chk("rr_onehot", 32'(rr_oh),    32'(e0));
        chk("fx_valid",  32'(fx_valid), 32'(m_valid[1]));
        chk("fx_busy",   32'(fx_busy),  32'(m_valid[1]));
        chk("fx_idx",    32'(fx_idx),   32'(m_idx[1]));
        chk("fx_onehot", 32'(fx_oh),    32'(e1));
    end

    task automatic cyc(input logic [W-1:0] r, input logic rd);
        req       = r;
        gnt_ready = rd;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [W-1:0] r, input logic rd);
        rst = 1'b1; req = r; gnt_ready = rd;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; gnt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rr_valid", 32'(rr_valid), 0);
        chk("reset_rr_onehot", 32'(rr_oh), 0);
        chk("reset_fx_valid", 32'(fx_valid), 0);
        chk("reset_fx_busy", 32'(fx_busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_rr_idx", 32'(rr_idx), 0);
        chk("first_rr_valid", 32'(rr_valid), 1);
        chk("first_fx_idx", 32'(fx_idx), 3);

        // Round-robin rotation under full load
        cyc(4'b1111, 1'b1); chk("rot1", 32'(rr_idx), 1);
        cyc(4'b1111, 1'b1); chk("rot2", 32'(rr_idx), 2);
        cyc(4'b1111, 1'b1); chk("rot3", 32'(rr_idx), 3);
        cyc(4'b1111, 1'b1); chk("rot0", 32'(rr_idx), 0);
        chk("rot_valid", 32'(rr_valid), 1);

        // Backpressure holds the grant stable
        do_reset(4'b0000, 1'b0);
        cyc(4'b0100, 1'b0); chk("bp_first", 32'(rr_idx), 2);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1100, 1'b0);
            chk("bp_hold_idx", 32'(rr_idx), 2);
            chk("bp_hold_oh", 32'(rr_oh), 32'h4);
        end
        cyc(4'b1100, 1'b1); chk("bp_next", 32'(rr_idx), 3);
        cyc(4'b1100, 1'b1); chk("bp_wrap", 32'(rr_idx), 2);
        cyc(4'b0101, 1'b1); chk("wrap_mask", 32'(rr_idx), 0);
        cyc(4'b0001, 1'b1); chk("single_gap0", 32'(rr_valid), 0);
        cyc(4'b0001, 1'b1); chk("single_gnt0", 32'(rr_valid), 1);
        cyc(4'b0001, 1'b1); chk("single_gap1", 32'(rr_valid), 0);
        cyc(4'b0001, 1'b1); chk("single_gnt1", 32'(rr_valid), 1);

        // Fixed priority alternates with the masked cycle
        do_reset(4'b1001, 1'b1);
        @(negedge clk);     chk("fx_seq0", 32'(fx_idx), 3);
        cyc(4'b1001, 1'b1); chk("fx_seq1", 32'(fx_idx), 0);
        cyc(4'b1001, 1'b1); chk("fx_seq2", 32'(fx_idx), 3);
        cyc(4'b1001, 1'b1); chk("fx_seq3", 32'(fx_idx), 0);

        // Reset mid-grant with a non-zero pointer
        do_reset(4'b0000, 1'b0);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1); chk("mid_idle", 32'(rr_valid), 0);
        cyc(4'b0100, 1'b0); chk("mid_gnt", 32'(rr_idx), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rr_valid", 32'(rr_valid), 0);
        chk("async_rr_oh", 32'(rr_oh), 0);
        chk("async_rr_idx", 32'(rr_idx), 0);
        chk("async_fx_busy", 32'(fx_busy), 0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1111; gnt_ready = 1'b0;
        @(negedge clk);
        chk("restart_idx", 32'(rr_idx), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(W'($urandom % 16), ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
